// File: rtl/eth_fcs_check_if.sv
// Byte-stream bus of the RX FCS checker: received bytes in, stripped payload and frame status out.
// master = upstream deframer side, slave = eth_fcs_check.
interface eth_fcs_check_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        crc_ok;
   logic        crc_err;
   logic        len_err;
   logic [11:0] frame_len;
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;

   modport master (
      output in_valid, in_data, in_last,
      input  out_valid, out_data, out_last, crc_ok, crc_err, len_err,
             frame_len, good_cnt, bad_cnt
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output out_valid, out_data, out_last, crc_ok, crc_err, len_err,
             frame_len, good_cnt, bad_cnt
   );
endinterface

// File: rtl/eth_fcs_check.sv
// Ethernet RX FCS checker: strips the 4-byte FCS through a delay line and checks the CRC-32 residue.
// Optional good/bad frame counters are enabled with the ETH_FCS_STAT_EN macro.
module eth_fcs_check #(
   parameter int                 datalen     = 8,
   parameter int                 crc_len     = 32,
   parameter logic [crc_len-1:0] crc_poly    = 32'h04C11DB7,
   parameter logic [crc_len-1:0] crc_residue = 32'hC704DD7B
) (
   input logic          clk,
   input logic          rst,
   eth_fcs_check_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   state_t               state_q, state_d;
   logic [2:0]           fill_q, fill_d;
   logic [datalen-1:0]   buf_q [4];
   logic [datalen-1:0]   buf_d [4];
   logic [crc_len-1:0]   crc_q, crc_d, crc_upd;
   logic [11:0]          tot_q, tot_d, tot_inc;
   logic                 ov_q, ov_d;
   logic [datalen-1:0]   od_q, od_d;
   logic                 ol_q, ol_d;
   logic                 ok_q, ok_d;
   logic                 err_q, err_d;
   logic                 lerr_q, lerr_d;
   logic [11:0]          flen_q, flen_d;

   // Wire-order bytes are LSB-first, so reflect before feeding the MSB-first engine.
   function automatic logic [crc_len-1:0] crc_step(input logic [crc_len-1:0] c,
                                                   input logic [datalen-1:0] b);
      logic [crc_len-1:0] r;
      logic [datalen-1:0] rb;
      for (int i = 0; i < datalen; i++) rb[i] = b[datalen-1-i];
      r = c ^ {rb, {(crc_len-datalen){1'b0}}};
      for (int i = 0; i < datalen; i++)
         r = r[crc_len-1] ? ((r << 1) ^ crc_poly) : (r << 1);
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      buf_d   = buf_q;
      crc_d   = crc_q;
      tot_d   = tot_q;
      ov_d    = 1'b0;
      od_d    = od_q;
      ol_d    = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      lerr_d  = 1'b0;
      flen_d  = flen_q;
      crc_upd = crc_step(crc_q, bus.in_data);
      tot_inc = (tot_q == 12'hFFF) ? tot_q : tot_q + 12'd1;

      if (bus.in_valid) begin
         crc_d = crc_upd;
         tot_d = tot_inc;
         if (state_q == STREAM) begin
            ov_d     = 1'b1;
            od_d     = buf_q[0];
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            buf_d[2] = buf_q[3];
            buf_d[3] = bus.in_data;
         end else begin
            buf_d[fill_q[1:0]] = bus.in_data;
            fill_d  = fill_q + 3'd1;
            state_d = (fill_q == 3'd3) ? STREAM : FILL;
         end

         // Frame end: bytes left in the buffer are the FCS and are dropped.
         if (bus.in_last) begin
            state_d = IDLE;
            fill_d  = 3'd0;
            crc_d   = '1;
            tot_d   = 12'd0;
            if (state_q == STREAM) begin
               ol_d   = 1'b1;
               ok_d   = (crc_upd == crc_residue);
               err_d  = (crc_upd != crc_residue);
               flen_d = tot_inc - 12'd4;
            end else begin
               err_d  = 1'b1;
               lerr_d = 1'b1;
               flen_d = 12'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         fill_q  <= 3'd0;
         for (int i = 0; i < 4; i++) buf_q[i] <= '0;
         crc_q   <= '1;
         tot_q   <= 12'd0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         ol_q    <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         lerr_q  <= 1'b0;
         flen_q  <= 12'd0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         buf_q   <= buf_d;
         crc_q   <= crc_d;
         tot_q   <= tot_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         ol_q    <= ol_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         lerr_q  <= lerr_d;
         flen_q  <= flen_d;
      end
   end

   assign bus.out_valid = ov_q;
   assign bus.out_data  = od_q;
   assign bus.out_last  = ol_q;
   assign bus.crc_ok    = ok_q;
   assign bus.crc_err   = err_q;
   assign bus.len_err   = lerr_q;
   assign bus.frame_len = flen_q;

`ifdef ETH_FCS_STAT_EN
   logic [15:0] good_q, bad_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         good_q <= 16'd0;
         bad_q  <= 16'd0;
      end else begin
         if (ok_d && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
         if (err_d && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
      end
   end

   assign bus.good_cnt = good_q;
   assign bus.bad_cnt  = bad_q;
`else
   assign bus.good_cnt = 16'd0;
   assign bus.bad_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_eth_fcs_check.sv
// Directed bench for eth_fcs_check: table of frames with known FCS plus back-to-back,
// mid-frame reset and idle in_last sequences.
module tb_eth_fcs_check;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   eth_fcs_check_if bus();
   eth_fcs_check dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef ETH_FCS_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   // "123456789" + FCS CBF43926 sent LSB first; byte 0 sits in the low bits.
   localparam logic [127:0] GOOD = {24'h0, 8'hCB, 8'hF4, 8'h39, 8'h26, 8'h39, 8'h38,
                                    8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
   localparam logic [127:0] BAD  = {24'h0, 8'hCA, 8'hF4, 8'h39, 8'h26, 8'h39, 8'h38,
                                    8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
   localparam logic [127:0] RUNT = {96'h0, 8'hCB, 8'hF4, 8'h39, 8'h26};
   localparam logic [127:0] ONEB = {120'h0, 8'h31};
   // "a" + FCS E8B7BE43.
   localparam logic [127:0] MINF = {88'h0, 8'hE8, 8'hB7, 8'hBE, 8'h43, 8'h61};

   typedef struct {
      logic [127:0] d;
      int           n;
      int           gmax;
      bit           ok;
      bit           lerr;
      int           flen;
   } vec_t;

   typedef struct {
      logic        ok;
      logic        err;
      logic        lerr;
      logic        last;
      logic [11:0] flen;
   } st_t;

   logic [7:0] pay_q[$];
   st_t        st_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         exp_good = 0;
   int         exp_bad  = 0;

   always @(negedge clk) begin
      if (rst) begin
         if (bus.out_valid) pay_q.push_back(bus.out_data);
         if (bus.crc_ok || bus.crc_err)
            st_q.push_back('{ok: bus.crc_ok, err: bus.crc_err, lerr: bus.len_err,
                             last: bus.out_last, flen: bus.frame_len});
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [127:0] d, input int n, input int gmax, input bit do_last);
      for (int i = 0; i < n; i++) begin
         if (i > 0 && gmax > 0) begin
            int g;
            g = $urandom_range(gmax, 0);
            repeat (g) begin
               bus.in_valid = 1'b0;
               bus.in_last  = 1'b1;
               bus.in_data  = 8'hA5;
               @(posedge clk); #1;
            end
         end
         bus.in_valid = 1'b1;
         bus.in_data  = d[8*i +: 8];
         bus.in_last  = do_last && (i == n - 1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic check_status(input string nm, input bit ok, input bit lerr, input int flen);
      st_t s;
      chk({nm, " pulse"}, (st_q.size() > 0), 1);
      if (st_q.size() > 0) begin
         s = st_q.pop_front();
         chk({nm, " crc_ok"},    s.ok,   ok);
         chk({nm, " crc_err"},   s.err,  !ok);
         chk({nm, " len_err"},   s.lerr, lerr);
         chk({nm, " out_last"},  s.last, !lerr);
         chk({nm, " frame_len"}, s.flen, flen);
      end
   endtask

   task automatic check_counters(input string nm);
      chk({nm, " good_cnt"}, bus.good_cnt, STAT ? exp_good : 0);
      chk({nm, " bad_cnt"},  bus.bad_cnt,  STAT ? exp_bad  : 0);
   endtask

   vec_t vt[6];

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;

      vt[0] = '{d: GOOD, n: 13, gmax: 0, ok: 1'b1, lerr: 1'b0, flen: 9};
      vt[1] = '{d: BAD,  n: 13, gmax: 0, ok: 1'b0, lerr: 1'b0, flen: 9};
      vt[2] = '{d: RUNT, n: 4,  gmax: 0, ok: 1'b0, lerr: 1'b1, flen: 0};
      vt[3] = '{d: GOOD, n: 13, gmax: 3, ok: 1'b1, lerr: 1'b0, flen: 9};
      vt[4] = '{d: ONEB, n: 1,  gmax: 0, ok: 1'b0, lerr: 1'b1, flen: 0};
      vt[5] = '{d: MINF, n: 5,  gmax: 2, ok: 1'b1, lerr: 1'b0, flen: 1};

      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset out_last",  bus.out_last,  0);
      chk("reset crc_ok",    bus.crc_ok,    0);
      chk("reset crc_err",   bus.crc_err,   0);
      chk("reset len_err",   bus.len_err,   0);
      chk("reset out_data",  bus.out_data,  0);
      chk("reset frame_len", bus.frame_len, 0);
      check_counters("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 6; v++) begin
         string nm;
         int    npay;
         nm = $sformatf("vec%0d", v);
         pay_q.delete();
         st_q.delete();
         send(vt[v].d, vt[v].n, vt[v].gmax, 1'b1);
         repeat (3) @(negedge clk);
         if (vt[v].ok) exp_good++; else exp_bad++;
         check_status(nm, vt[v].ok, vt[v].lerr, vt[v].flen);
         chk({nm, " extra pulses"}, st_q.size(), 0);
         npay = vt[v].lerr ? 0 : vt[v].n - 4;
         chk({nm, " payload count"}, pay_q.size(), npay);
         for (int i = 0; i < npay && i < pay_q.size(); i++)
            chk($sformatf("%s payload[%0d]", nm, i), pay_q[i], vt[v].d[8*i +: 8]);
         check_counters(nm);
      end

      // Two good frames back-to-back with random gaps, no idle between them.
      pay_q.delete();
      st_q.delete();
      send(GOOD, 13, 3, 1'b1);
      send(GOOD, 13, 3, 1'b1);
      repeat (3) @(negedge clk);
      exp_good += 2;
      check_status("b2b first",  1'b1, 1'b0, 9);
      check_status("b2b second", 1'b1, 1'b0, 9);
      chk("b2b payload count", pay_q.size(), 18);
      for (int i = 0; i < 18 && i < pay_q.size(); i++)
         chk($sformatf("b2b payload[%0d]", i), pay_q[i], GOOD[8*(i % 9) +: 8]);
      check_counters("b2b");

      // in_last held high with in_valid low while idle must do nothing.
      pay_q.delete();
      st_q.delete();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b1;
      bus.in_data  = 8'hCB;
      repeat (6) @(posedge clk);
      #1;
      bus.in_last = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle last pulses",  st_q.size(), 0);
      chk("idle last payload", pay_q.size(), 0);
      check_counters("idle last");

      // Reset after byte 6: the partial frame vanishes and outputs clear at once.
      send(GOOD, 6, 0, 1'b0);
      chk("pre-reset out_valid", bus.out_valid, 1);
      rst = 1'b0;
      #1;
      chk("async reset out_valid", bus.out_valid, 0);
      chk("async reset out_data",  bus.out_data,  0);
      exp_good = 0;
      exp_bad  = 0;
      check_counters("async reset");
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort pulses", st_q.size(), 0);
      pay_q.delete();
      st_q.delete();
      send(GOOD, 13, 0, 1'b1);
      repeat (3) @(negedge clk);
      exp_good++;
      check_status("after reset", 1'b1, 1'b0, 9);
      chk("after reset payload count", pay_q.size(), 9);
      for (int i = 0; i < 9 && i < pay_q.size(); i++)
         chk($sformatf("after reset payload[%0d]", i), pay_q[i], GOOD[8*i +: 8]);
      check_counters("after reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_fcs_check.md
# eth_fcs_check

Receive-side counterpart of the CRC-32 FCS generator. It consumes a received Ethernet frame as a byte stream, payload followed by the 4-byte FCS, and strips the FCS through a 4-byte delay line. It recomputes CRC-32 over every byte, including the FCS, and reports pass/fail by residue comparison. It sits between the RX byte deframer and the RX payload buffer.

## Interface
- `datalen`, 8: byte width, fixed at 8.
- `crc_len`, 32: CRC width.
- `crc_poly`, 32'h04C11DB7: generator polynomial, same value as the TX CRC generator.
- `crc_residue`, 32'hC704DD7B: expected register value after a good frame.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input byte valid this cycle.
- `in_data` in 8: received byte, wire order.
- `in_last` in 1: with `in_valid`, marks the final FCS byte.
- `out_valid` out 1: payload byte valid.
- `out_data` out 8: payload byte.
- `out_last` out 1: final payload byte.
- `crc_ok` out 1: one-cycle pulse, frame passed.
- `crc_err` out 1: one-cycle pulse, frame failed (bad FCS or runt).
- `len_err` out 1: one-cycle pulse with `crc_err`, frame shorter than 5 bytes.
- `frame_len` out 12: payload byte count, valid while `crc_ok` or `crc_err` is high.
- `good_cnt` out 16: good-frame counter (see Configuration).
- `bad_cnt` out 16: bad-frame counter (see Configuration).

## Operation
- CRC engine per accepted byte:
  - reflect the byte;
  - XOR it into bits [31:24] of the accumulator;
  - run 8 MSB-first shift/XOR steps with `crc_poly`.
- The accumulator initialises to 32'hFFFFFFFF at reset and at the first byte of each frame.
- No output reflection or inversion is applied. At `in_last` the updated accumulator is compared to `crc_residue`.
- Delay line: a 4-entry shift buffer plus a fill count (0–4).
  - An accepted byte with fill == 4 emits the oldest entry as a payload byte, then shifts the new byte in.
  - The 4 entries left at `in_last` are the FCS and are discarded.
- FSM:
  - IDLE: no bytes buffered. Any accepted byte goes to FILL.
  - FILL: 1–3 bytes buffered. The byte that brings the buffer to 4 goes to STREAM.
  - STREAM: buffer full, each accepted byte emits one payload byte.
  - From any state, `in_last` goes to IDLE, clears fill and resets the CRC for the next frame.
- Runt frame: `in_last` while total bytes < 5, i.e. `in_last` accepted outside STREAM.
  - Assert `crc_err` and `len_err`; `frame_len` = 0.
  - No `out_valid` is produced for the frame.
- Length: `frame_len` = total accepted − 4. The total counter saturates at 4095, so `frame_len` saturates at 4091.
- Gaps: `in_valid` low mid-frame holds all state. No timeout.
- `in_last` with `in_valid` low is ignored.
- `crc_ok` and `crc_err` are mutually exclusive.

## Timing
- All outputs are registered.
- Reset values: `out_valid`, `out_last`, `crc_ok`, `crc_err`, `len_err` = 0; `out_data`, `frame_len`, `good_cnt`, `bad_cnt` = 0; FSM = IDLE; CRC accumulator = all ones.
- Payload byte k appears on `out_data` with `out_valid` one cycle after byte k+4 is accepted.
- `out_last`, `crc_ok`/`crc_err`, `len_err` and `frame_len` are all asserted one cycle after `in_last` is accepted. `out_last` coincides with the status pulse.
- Back-to-back frames: a byte accepted in the cycle after `in_last` is the first byte of the next frame. It is handled with fresh CRC and fill state, with no dead cycle.
- Reset asserted mid-frame:
  - the partial frame is discarded;
  - no status pulse or counter update;
  - outputs take their reset values immediately (asynchronously).

## Configuration
- `ETH_FCS_STAT_EN` defined: `good_cnt` / `bad_cnt` increment on `crc_ok` / `crc_err`, saturate at 16'hFFFF, and are cleared only by `rst`.
- `ETH_FCS_STAT_EN` undefined: counter logic is omitted; both ports are tied to 0.

## Test plan
- Bytes 31 32 33 34 35 36 37 38 39 26 39 F4 CB, with `in_last` on CB -> `out_data` 31..39, `out_last` on 39, `crc_ok` = 1, `frame_len` = 9.
- Same frame with the final byte CA -> payload still emitted, `crc_err` = 1, `crc_ok` = 0, `frame_len` = 9, `bad_cnt` +1 when `ETH_FCS_STAT_EN` is defined.
- 4-byte frame 26 39 F4 CB with `in_last` -> no `out_valid`, `crc_err` = 1, `len_err` = 1, `frame_len` = 0.
- The good 13-byte frame with random 0–3 cycle `in_valid` gaps, sent twice back-to-back with no idle -> two `crc_ok` pulses, identical payloads, `good_cnt` = 2.
- `rst` low after byte 6 of the good frame, then the full good frame resent -> no pulse for the aborted frame; the second frame gives `crc_ok`.
- Stimulus driven with `in_last` held high while `in_valid` is low -> no effect on state or outputs.
